io_uart_in: RTL and testbench
=============================

# io_uart_in

Memory-mapped UART receive peripheral on the DMA-IO bus; the read-side counterpart to the UART output IO block. It buffers characters delivered by the UART front end in a small FIFO. The CPU drains them through IO-bus reads. Sticky overflow and an optional level interrupt are provided. It sits in the IO read-data daisy chain like the other IO blocks.

## Interface
- FIFO_AW, 4 — log2 FIFO depth (16 entries)
- ADR_RXDATA, 14'h3F04 — word address [15:2] of RXDATA (byte 0xFC10)
- ADR_RXSTAT, 14'h3F05 — word address [15:2] of RXSTAT (byte 0xFC14)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx_char  in  8  received character from UART front end
- uart_rx_we  in  1  one-cycle strobe; uart_rx_char valid
- dma_io_we  in  1  IO write strobe
- dma_io_wadr  in  14 [15:2]  IO write word address
- dma_io_wdata  in  32  IO write data
- dma_io_radr  in  14 [15:2]  IO read word address
- dma_io_radr_en  in  1  IO read strobe
- dma_io_rdata_in  in  32  read data from upstream IO block
- dma_io_rdata  out  32  read data to downstream (own data or pass-through)
- rx_int  out  1  level interrupt: FIFO non-empty and int enable set

## Operation
- Push: uart_rx_we=1 and FIFO not full (or popping same cycle) → char written at wptr, count+1.
- Push while full without pop → char dropped, ovf sticky set, count unchanged.
- Pop: dma_io_radr_en=1, dma_io_radr==ADR_RXDATA, FIFO non-empty → rptr advances, count−1.
- Simultaneous push+pop: both occur, count unchanged; legal at full and at empty+1.
- Read RXDATA: {23'd0, valid, char}; valid=1 if an entry was popped. Empty read returns 32'd0, no side effect.
- Read RXSTAT: {15'd0, ie, 5'd0, ovf, full, empty, 3'd0, count[4:0]} (count at bits 4:0, empty bit8, full bit9, ovf bit10, ie bit16). No side effect.
- Write RXSTAT: bit0=1 flush (ptrs and count to 0); bit10=1 clears ovf; bit16 loads ie.
- Flush same cycle as push: flush wins, char discarded, ovf not set. Flush same cycle as pop: flush wins, read data still returns the popped entry.
- Writes to RXDATA ignored; other addresses ignored.
- Pointers FIFO_AW bits, wrap modulo depth; count FIFO_AW+1 bits, full when count==2**FIFO_AW.
- rx_int = ie & ~empty, registered.

## Timing
- Reset: ptrs, count, ovf, ie = 0; rdata hold reg = 0; hit flag = 0; rx_int = 0; dma_io_rdata = dma_io_rdata_in (pass-through).
- Read latency 1: cycle N strobe+address; cycle N+1 dma_io_rdata carries own data if hit at N, else dma_io_rdata_in combinationally.
- Hit flag and data register load only on radr_en; held otherwise (output stays own data until next radr_en).
- Pushed char visible to read strobe next cycle; count/empty/full update one cycle after event.
- rx_int asserts 1 cycle after the first push into empty FIFO with ie=1; deasserts 1 cycle after last pop.
- Back-to-back reads every cycle supported, one pop per cycle.
- Reset mid-operation: all state cleared immediately; FIFO contents lost.

## Structure
- Shared package/include: ADR_RXDATA, ADR_RXSTAT, RXSTAT bit positions (CNT, EMPTY, FULL, OVF, IE, FLUSH).
- Sub-module io_uart_in_fifo: synchronous FIFO (push, pop, flush, dout, count, empty, full) parameterised by FIFO_AW; register decode, overflow, interrupt, read mux in io_uart_in.

## Test plan
- Push 'A','B','C' (0x41,0x42,0x43), read RXDATA ×4 → 0x141, 0x142, 0x143, then 0x0; RXSTAT count 0, empty=1.
- Push 17 chars 0x30..0x40 without reading → count=16, full=1, ovf=1; 16 reads return 0x130..0x13F; write RXSTAT 0x400 → ovf=0.
- At full, push 0x55 same cycle as RXDATA read → read returns oldest, count stays 16, ovf=0, 0x55 is last entry read.
- Write RXSTAT 0x10000, push 0x61 → rx_int=1 one cycle later; read RXDATA → rx_int=0 next cycle; write RXSTAT 0x0 → rx_int stays 0 with data queued.
- Push 5 chars, write RXSTAT 0x1 same cycle as push 0x7A → count=0, empty=1, ovf=0, RXDATA read 0x0.
- Read unrelated address with dma_io_rdata_in=0xDEADBEEF → dma_io_rdata=0xDEADBEEF; assert rst_n low mid-burst → count 0, rx_int 0, pass-through.

Source files
------------

// File: rtl/io_uart_in_pkg.sv
// Shared constants and helpers for the UART receive IO block.
package io_uart_in_pkg;

    // FIFO geometry: 2**FIFO_AW character entries
    localparam int FIFO_AW = 4;

    // IO word addresses (byte address bits [15:2])
    localparam logic [13:0] ADR_RXDATA = 14'h3F04;
    localparam logic [13:0] ADR_RXSTAT = 14'h3F05;

    // RXSTAT bit positions
    localparam int RXSTAT_CNT   = 0;
    localparam int RXSTAT_EMPTY = 8;
    localparam int RXSTAT_FULL  = 9;
    localparam int RXSTAT_OVF   = 10;
    localparam int RXSTAT_IE    = 16;
    localparam int RXSTAT_FLUSH = 0;

    typedef struct packed {
        logic               ie;
        logic               ovf;
        logic               full;
        logic               empty;
        logic [FIFO_AW:0]   count;
    } rxstat_t;

    // Pack the status fields into the 32-bit RXSTAT read word
    function automatic logic [31:0] pack_rxstat(input rxstat_t s);
        logic [31:0] w;
        w = '0;
        w[RXSTAT_CNT +: FIFO_AW+1] = s.count;
        w[RXSTAT_EMPTY]            = s.empty;
        w[RXSTAT_FULL]             = s.full;
        w[RXSTAT_OVF]              = s.ovf;
        w[RXSTAT_IE]               = s.ie;
        return w;
    endfunction

endpackage

// File: rtl/io_uart_in_if.sv
// Bus bundle for the UART receive block: UART front-end strobe, IO bus, interrupt.
interface io_uart_in_if;
    logic [7:0]  uart_rx_char;
    logic        uart_rx_we;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        rx_int;

    // Bus side: drives the front-end and IO bus, observes read data and interrupt
    modport master (
        output uart_rx_char, uart_rx_we,
        output dma_io_we, dma_io_wadr, dma_io_wdata,
        output dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
        input  dma_io_rdata, rx_int
    );

    // Peripheral side
    modport slave (
        input  uart_rx_char, uart_rx_we,
        input  dma_io_we, dma_io_wadr, dma_io_wdata,
        input  dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
        output dma_io_rdata, rx_int
    );
endinterface

// File: rtl/io_uart_in_fifo.sv
// Synchronous character FIFO with flush; combinational head-of-queue output.
module io_uart_in_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [7:0]         i_din,
    output logic [7:0]         o_dout,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_empty,
    output logic               o_full
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Flush overrides both operations; a pop frees a slot so push at full is accepted
    assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~w_full | (i_pop & ~w_empty));

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/io_uart_in.sv
// UART receive IO block: register decode, overflow, interrupt and read-data chain.
module io_uart_in
    import io_uart_in_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    io_uart_in_if.slave     bus
);
    logic               w_rd_rxdata;
    logic               w_rd_rxstat;
    logic               w_wr_rxstat;
    logic               w_flush;
    logic               w_pop_ok;
    logic               w_ovf_set;
    logic [7:0]         w_dout;
    logic [FIFO_AW:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic [31:0]        w_rd_word;
    rxstat_t            w_stat;
    logic               w_unused_bits;

    logic               r_ovf;
    logic               r_ie;
    logic               r_hit;
    logic [31:0]        r_rdata;
    logic               r_rx_int;

    assign w_rd_rxdata = bus.dma_io_radr_en & (bus.dma_io_radr == ADR_RXDATA);
    assign w_rd_rxstat = bus.dma_io_radr_en & (bus.dma_io_radr == ADR_RXSTAT);
    assign w_wr_rxstat = bus.dma_io_we & (bus.dma_io_wadr == ADR_RXSTAT);
    assign w_flush     = w_wr_rxstat & bus.dma_io_wdata[RXSTAT_FLUSH];
    assign w_pop_ok    = w_rd_rxdata & ~w_empty;

    // A char is lost only when full with no pop to make room; a flush discards silently
    assign w_ovf_set   = bus.uart_rx_we & w_full & ~w_pop_ok & ~w_flush;

    assign w_unused_bits = ^{bus.dma_io_wdata[31:17], bus.dma_io_wdata[15:11],
                             bus.dma_io_wdata[9:1]};

    io_uart_in_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.uart_rx_we),
        .i_pop   (w_rd_rxdata),
        .i_flush (w_flush),
        .i_din   (bus.uart_rx_char),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_stat = '{ie: r_ie, ovf: r_ovf, full: w_full, empty: w_empty, count: w_count};

    // Select the word this block would return for the current read strobe
    always_comb begin
        w_rd_word = '0;
        if (w_pop_ok) begin
            w_rd_word = {23'd0, 1'b1, w_dout};
        end else if (w_rd_rxstat) begin
            w_rd_word = pack_rxstat(w_stat);
        end
    end

    // Sticky overflow (a new loss wins over a simultaneous clear) and interrupt enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_ie  <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_rxstat && bus.dma_io_wdata[RXSTAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_rxstat) begin
                r_ie <= bus.dma_io_wdata[RXSTAT_IE];
            end
        end
    end

    // Read capture: hit and data only change on a read strobe, otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else if (bus.dma_io_radr_en) begin
            r_hit   <= w_rd_rxdata | w_rd_rxstat;
            r_rdata <= w_rd_word;
        end
    end

    // Level interrupt, registered from current enable and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_int <= 1'b0;
        end else begin
            r_rx_int <= r_ie & ~w_empty;
        end
    end

    assign bus.dma_io_rdata = r_hit ? r_rdata : bus.dma_io_rdata_in;
    assign bus.rx_int       = r_rx_int;

endmodule

// File: tb/tb_io_uart_in.sv
// Scoreboard bench for io_uart_in: stimulus queues expected read words, a monitor checks them.
module tb_io_uart_in;
    import io_uart_in_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_uart_in_if bus ();

    io_uart_in dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] UPSTREAM = 32'hDEADBEEF;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One bus cycle, inputs changed on the falling edge
    task automatic drive(input logic push, input logic [7:0] ch,
                         input logic rd, input logic [13:0] ra,
                         input logic we, input logic [13:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.uart_rx_we     = push;
        bus.uart_rx_char   = ch;
        bus.dma_io_radr_en = rd;
        bus.dma_io_radr    = ra;
        bus.dma_io_we      = we;
        bus.dma_io_wadr    = wa;
        bus.dma_io_wdata   = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 14'h0, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic push_ch(input logic [7:0] c);
        drive(1'b1, c, 1'b0, 14'h0, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic rd_data(input logic [31:0] exp);
        sb.push_back(exp);
        drive(1'b0, 8'h00, 1'b1, ADR_RXDATA, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic rd_stat(input logic [31:0] exp);
        sb.push_back(exp);
        drive(1'b0, 8'h00, 1'b1, ADR_RXSTAT, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic wr_stat(input logic [31:0] v);
        drive(1'b0, 8'h00, 1'b0, 14'h0, 1'b1, ADR_RXSTAT, v);
    endtask

    // Monitor: every accepted read strobe produces one word on the next cycle
    initial begin
        logic [31:0] exp;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && bus.dma_io_radr_en === 1'b1) begin
                #1;
                if (sb.size() == 0) begin
                    check("sb_underflow", bus.dma_io_rdata, 32'hxxxxxxxx);
                end else begin
                    exp = sb.pop_front();
                    check("rdata", bus.dma_io_rdata, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.uart_rx_we      = 1'b0;
        bus.uart_rx_char    = 8'h00;
        bus.dma_io_we       = 1'b0;
        bus.dma_io_wadr     = 14'h0;
        bus.dma_io_wdata    = 32'h0;
        bus.dma_io_radr     = 14'h0;
        bus.dma_io_radr_en  = 1'b0;
        bus.dma_io_rdata_in = UPSTREAM;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_passthru", bus.dma_io_rdata, UPSTREAM);
        check("rst_int", {31'd0, bus.rx_int}, 32'd0);
        rst_n = 1'b1;
        rd_stat(32'h0000_0100);

        // Basic push / drain, including an empty read
        push_ch(8'h41); push_ch(8'h42); push_ch(8'h43);
        rd_data(32'h141); rd_data(32'h142); rd_data(32'h143); rd_data(32'h0);
        rd_stat(32'h0000_0100);
        idle(2);
        check("hold_own", bus.dma_io_rdata, 32'h0000_0100);

        // Overfill: 17 pushes, last dropped
        for (int i = 0; i < 17; i++) push_ch(8'(8'h30 + i));
        rd_stat(32'h0000_0610);
        for (int i = 0; i < 16; i++) rd_data(32'h130 + 32'(i));
        rd_stat(32'h0000_0500);
        wr_stat(32'h0000_0400);
        rd_stat(32'h0000_0100);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push_ch(8'(8'h80 + i));
        sb.push_back(32'h180);
        drive(1'b1, 8'h55, 1'b1, ADR_RXDATA, 1'b0, 14'h0, 32'h0);
        rd_stat(32'h0000_0210);
        for (int i = 1; i < 16; i++) rd_data(32'h180 + 32'(i));
        rd_data(32'h155);
        rd_data(32'h0);

        // Interrupt enable / disable
        wr_stat(32'h0001_0000);
        push_ch(8'h61);
        idle(2);
        check("int_on", {31'd0, bus.rx_int}, 32'd1);
        rd_data(32'h161);
        idle(2);
        check("int_off_empty", {31'd0, bus.rx_int}, 32'd0);
        rd_stat(32'h0001_0100);
        wr_stat(32'h0);
        push_ch(8'h62);
        idle(2);
        check("int_disabled", {31'd0, bus.rx_int}, 32'd0);
        rd_stat(32'h0000_0001);
        rd_data(32'h162);

        // Flush beats a simultaneous push
        for (int i = 0; i < 5; i++) push_ch(8'(8'h01 + i));
        drive(1'b1, 8'h7A, 1'b0, 14'h0, 1'b1, ADR_RXSTAT, 32'h1);
        rd_stat(32'h0000_0100);
        rd_data(32'h0);

        // Flush beats a simultaneous pop but the popped char is still returned
        push_ch(8'h11); push_ch(8'h12);
        sb.push_back(32'h111);
        drive(1'b0, 8'h00, 1'b1, ADR_RXDATA, 1'b1, ADR_RXSTAT, 32'h1);
        rd_stat(32'h0000_0100);

        // Unrelated address passes upstream data through
        sb.push_back(UPSTREAM);
        drive(1'b0, 8'h00, 1'b1, 14'h0001, 1'b0, 14'h0, 32'h0);

        // Reset in the middle of activity
        wr_stat(32'h0001_0000);
        push_ch(8'hA1); push_ch(8'hA2); push_ch(8'hA3);
        idle(2);
        check("int_pre_rst", {31'd0, bus.rx_int}, 32'd1);
        rd_data(32'h1A1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.dma_io_radr_en = 1'b0;
        #1;
        check("rst_mid_int", {31'd0, bus.rx_int}, 32'd0);
        check("rst_mid_passthru", bus.dma_io_rdata, UPSTREAM);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_stat(32'h0000_0100);
        rd_data(32'h0);

        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
